// File: rtl/muldiv_pkg.sv
// Shared types and opcode helpers for the iterative RV32M multiply/divide unit.
// The optional early-out behaviour (MULDIV_EARLY_OUT_EN) lives in muldiv_unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } muldiv_state_e;

  function automatic logic is_div(muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(muldiv_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_div(muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op1_signed(muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op2_signed(muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring
// divide step on a 2*DATA_WIDTH accumulator {hi, lo}.
module muldiv_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] acc_i,
  input  logic                    is_div_i,
  input  logic [DATA_WIDTH-1:0]   operand_i,
  output logic [2*DATA_WIDTH-1:0] acc_o,
  output logic                    q_bit_o
);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] partial;
  logic [DATA_WIDTH:0] diff;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    acc_o   = '0;
    q_bit_o = 1'b0;

    // Multiply: lo holds the multiplier; the carry of hi+multiplicand shifts into the top.
    sum = {1'b0, acc_i[2*DATA_WIDTH-1:DATA_WIDTH]}
        + (acc_i[0] ? {1'b0, operand_i} : '0);

    // Divide: the partial remainder is hi with the next dividend bit appended.
    partial = acc_i[2*DATA_WIDTH-1:DATA_WIDTH-1];
    diff    = partial - {1'b0, operand_i};

    if (is_div_i) begin
      q_bit_o = ~diff[DATA_WIDTH];
      acc_o   = {(q_bit_o ? diff[DATA_WIDTH-1:0] : partial[DATA_WIDTH-1:0]),
                 acc_i[DATA_WIDTH-2:0], q_bit_o};
    end else begin
      acc_o   = {sum, acc_i[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready in and out, fixed
// DATA_WIDTH-cycle latency; MULDIV_EARLY_OUT_EN short-cuts div-by-zero/overflow.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  muldiv_state_e           state_q;
  logic                    out_valid_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    zero_q;

  muldiv_op_e              op_q;
  logic                    neg_q;
  logic                    div0_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   opnd_q;
  logic [2*DATA_WIDTH-1:0] acc_q;

  muldiv_op_e              op_in;
  logic                    sgn1, sgn2;
  logic [DATA_WIDTH-1:0]   mag1, mag2;
  logic                    neg_d, div0_d, accept;
  logic [2*DATA_WIDTH-1:0] step_acc, prod_fix;
  logic                    step_q;
  logic [DATA_WIDTH-1:0]   quot, rem, final_res;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

  always_comb begin
    op_in  = muldiv_op_e'(op[2:0]);
    sgn1   = op1_signed(op_in) && op1[DATA_WIDTH-1];
    sgn2   = op2_signed(op_in) && op2[DATA_WIDTH-1];
    mag1   = sgn1 ? -op1 : op1;
    mag2   = sgn2 ? -op2 : op2;
    // A remainder follows the dividend's sign; products and quotients use the XOR.
    neg_d  = is_rem(op_in) ? sgn1 : (sgn1 ^ sgn2);
    div0_d = is_div(op_in) && (op2 == '0);
    accept = in_valid && (state_q == ST_IDLE) && !flush;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic                  ovf_d;
  logic [DATA_WIDTH-1:0] special_res;

  always_comb begin
    ovf_d = is_signed_div(op_in) && (op1 == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (op2 == '1);
    if (div0_d) special_res = is_rem(op_in) ? op1 : '1;
    else        special_res = is_rem(op_in) ? '0  : op1;
  end
`endif

  muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .acc_i     (acc_q),
    .is_div_i  (is_div(op_q)),
    .operand_i (opnd_q),
    .acc_o     (step_acc),
    .q_bit_o   (step_q)
  );

  // The result is taken from the final iteration's output in the same cycle.
  always_comb begin
    prod_fix = neg_q ? -step_acc : step_acc;
    quot     = {step_acc[DATA_WIDTH-1:1], step_q};
    rem      = step_acc[2*DATA_WIDTH-1:DATA_WIDTH];
    case (op_q)
      OP_MUL:                       final_res = prod_fix[DATA_WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_DIV, OP_DIVU:              final_res = div0_q ? '1 : (neg_q ? -quot : quot);
      default:                      final_res = neg_q ? -rem : rem;
    endcase
  end

  // NOTE: datapath registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= op_in;
      neg_q  <= neg_d;
      div0_q <= div0_d;
      cnt_q  <= CNT_W'(DATA_WIDTH-1);
      opnd_q <= is_div(op_in) ? mag2 : mag1;
      acc_q  <= {{DATA_WIDTH{1'b0}}, (is_div(op_in) ? mag1 : mag2)};
    end else if (state_q == ST_CALC) begin
      acc_q  <= step_acc;
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) begin
`ifdef MULDIV_EARLY_OUT_EN
          if (div0_d || ovf_d) begin
            result_q    <= special_res;
            zero_q      <= (special_res == '0);
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            state_q     <= ST_CALC;
          end
`else
          state_q <= ST_CALC;
`endif
        end
        ST_CALC: if (cnt_q == '0) begin
          result_q    <= final_res;
          zero_q      <= (final_res == '0);
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M corner cases, backpressure,
// flush/reset aborts and randomized ops against an arithmetic reference model.
`timescale 1ns/1ps
module tb_muldiv_unit;
  localparam int W = 32;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    time          t_acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = '0;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   hold_low = 1'b0;
  bit   rand_ready = 1'b0;
  bit   seen = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_WIDTH(W), .CTRL_WIDTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op1       (op1),
    .op2       (op2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model straight from the RV32M arithmetic rules.
  function automatic logic [W-1:0] ref_model(input logic [2:0] f, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint       sa = longint'($signed(a));
    longint       sbv = longint'($signed(b));
    longint       ua = longint'(a);
    longint       ub = longint'(b);
    logic [63:0]  p;
    bit           ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub;  return p[31:0];  end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (ovf) return a;
        p = sa / sbv; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return '1;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return '0;
        p = sa % sbv; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    bit special = f[2] && ((b == '0) ||
                  ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return (EARLY && special) ? 1 : W;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  // out_ready driver: all flag changes land at posedge+1, applied at posedge+2.
  always @(posedge clk) begin
    #2;
    if (hold_low)        out_ready = 1'b0;
    else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    else                 out_ready = 1'b1;
  end

  // Monitor: compares the first cycle of each presented result, pops on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          check("result", result, sb[0].res);
          check("zero", zero, sb[0].res == '0);
          check("latency", ($time - 5 - sb[0].t_acc) / 10, sb[0].lat);
        end
      end
      if (out_ready) begin
        if (sb.size() != 0) void'(sb.pop_front());
        seen = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_res, input bit push, output time t_acc);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) check("issue_timeout", in_ready, 1'b1);
    in_valid = 1'b1; op = f; op1 = a; op2 = b;
    @(posedge clk);
    t_acc = $time;
    if (push) sb.push_back('{exp_res, exp_lat(f, a, b), t_acc});
    #1;
    in_valid = 1'b0;
    op  = 3'($urandom);
    op1 = W'($urandom);
    op2 = W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  logic [2:0]   d_op [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                               3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
  logic [W-1:0] d_a  [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                               32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9};
  logic [W-1:0] d_b  [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
  logic [W-1:0] d_r  [14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                               32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                               32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFF9};

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
    $fatal(1);
  end

  initial begin
    time t_acc, t_hs;
    bit  saw;
    int  n;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, '0);
    check("rst_zero", zero, 1'b1);

    for (int i = 0; i < 14; i++) issue(d_op[i], d_a[i], d_b[i], d_r[i], 1'b1, t_acc);
    drain();

    // Backpressure: result held, input pulses ignored, then release.
    hold_low = 1'b1;
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, t_acc);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) check("bp_wait_timeout", out_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; op = 3'($urandom); op1 = W'($urandom); op2 = W'($urandom);
      @(negedge clk);
      check("bp_result", result, 32'hFFFF_FFFE);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    hold_low = 1'b0;
    @(posedge clk);
    t_hs = $time;
    #1;
    check("release_in_ready", in_ready, 1'b1);
    check("release_out_valid", out_valid, 1'b0);
    issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b1, t_acc);
    check("b2b_accept_gap", (t_acc - t_hs) / 10, 64'd1);
    drain();

    // Flush mid-calculation, then flush racing in_valid in IDLE.
    issue(3'd0, 32'd123, 32'd456, '0, 1'b0, t_acc);
    repeat (15) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_out_valid", out_valid, 1'b0);
    in_valid = 1'b1; flush = 1'b1; op = 3'd4; op1 = 32'd9; op2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_beats_in_valid", in_ready, 1'b1);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("no_valid_after_flush", saw, 1'b0);

    // Reset mid-calculation after a non-zero result was registered.
    issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b1, t_acc);
    drain();
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, '0, 1'b0, t_acc);
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_result", result, '0);
    check("midrst_zero", zero, 1'b1);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("no_valid_after_reset", saw, 1'b0);

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [2:0]   f;
      logic [W-1:0] a, b;
      f = 3'($urandom);
      a = pick();
      b = pick();
      issue(f, a, b, ref_model(f, a, b), 1'b1, t_acc);
    end
    rand_ready = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
